// File: rtl/gameover_ctl_if.sv
// gameover_ctl_if: bundles the game-over controller's control inputs
// (restart request, result code, vertical blanking) and its outputs to the
// draw stage. master = the game/VGA side, slave = gameover_ctl.
interface gameover_ctl_if;
  logic       reset;
  logic [1:0] gameover;
  logic       vblnk;
  logic       over;
  logic [1:0] winner;
  logic       blink;
  logic       restart_done;

  modport master (
    output reset, gameover, vblnk,
    input  over, winner, blink, restart_done
  );

  modport slave (
    input  reset, gameover, vblnk,
    output over, winner, blink, restart_done
  );
endinterface

// File: rtl/gameover_ctl.sv
// gameover_ctl: confirms a stable non-zero game result over several frames,
// holds the over screen for a minimum number of frames, then waits for a
// player restart (reset asserted, then released with gameover back at 00).
// Optional macro GAMEOVER_BLINK_EN: blink toggles every BLINK_FRAMES frame
// ticks while over; without it blink simply follows over.
module gameover_ctl #(
  parameter int CONFIRM_FRAMES  = 2,
  parameter int MIN_OVER_FRAMES = 60,
  parameter int BLINK_FRAMES    = 30
) (
  input  logic          clk,
  input  logic          rst,
  gameover_ctl_if.slave bus
);

  localparam int MAX_CM = (CONFIRM_FRAMES > MIN_OVER_FRAMES) ? CONFIRM_FRAMES : MIN_OVER_FRAMES;
  localparam int MAX_P  = (MAX_CM > BLINK_FRAMES) ? MAX_CM : BLINK_FRAMES;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_FRAMES - 1);
  localparam logic [CW-1:0] OVER_SAT  = CW'(MIN_OVER_FRAMES);

  typedef enum logic [1:0] {PLAY, CONFIRM, OVER, RELEASE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    cand;
  logic          vblnk_q;
  logic          frame_tick;

`ifdef GAMEOVER_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_adv;
  logic          blink_adv;

  // Next blink counter / phase if the current cycle is spent in OVER or RELEASE
  always_comb begin
    bcnt_adv  = bcnt;
    blink_adv = bus.blink;
    if (frame_tick) begin
      if (bcnt == BLINK_LAST) begin
        bcnt_adv  = '0;
        blink_adv = ~bus.blink;
      end else begin
        bcnt_adv = bcnt + 1'b1;
      end
    end
  end
`endif

  // Frame tick: one clk pulse on each rising edge of vblnk
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vblnk_q    <= bus.vblnk;
      frame_tick <= bus.vblnk & ~vblnk_q;
    end
  end

  // Game-over FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= PLAY;
      cnt              <= '0;
      cand             <= '0;
      bus.over         <= 1'b0;
      bus.winner       <= '0;
      bus.blink        <= 1'b0;
      bus.restart_done <= 1'b0;
`ifdef GAMEOVER_BLINK_EN
      bcnt             <= '0;
`endif
    end else begin
      bus.restart_done <= 1'b0;
      case (state)
        PLAY: begin
          cnt <= '0;
          if (!bus.reset && bus.gameover != 2'b00) begin
            state <= CONFIRM;
            cand  <= bus.gameover;
          end
        end
        CONFIRM: begin
          if (bus.reset || bus.gameover == 2'b00) begin
            state <= PLAY;
            cnt   <= '0;
          end else if (bus.gameover != cand) begin
            cand <= bus.gameover;
            cnt  <= '0;
          end else if (frame_tick) begin
            // Transition happens on the tick that completes the count
            if (cnt == CONF_LAST) begin
              state      <= OVER;
              cnt        <= '0;
              bus.over   <= 1'b1;
              bus.winner <= cand;
              bus.blink  <= 1'b1;
`ifdef GAMEOVER_BLINK_EN
              bcnt       <= '0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        OVER: begin
`ifdef GAMEOVER_BLINK_EN
          bcnt      <= bcnt_adv;
          bus.blink <= blink_adv;
`endif
          if (cnt == OVER_SAT && bus.reset) begin
            state <= RELEASE;
            cnt   <= '0;
          end else if (frame_tick && cnt != OVER_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!bus.reset && bus.gameover == 2'b00) begin
            state            <= PLAY;
            cand             <= '0;
            bus.over         <= 1'b0;
            bus.winner       <= '0;
            bus.blink        <= 1'b0;
            bus.restart_done <= 1'b1;
`ifdef GAMEOVER_BLINK_EN
            bcnt             <= '0;
`endif
          end else begin
`ifdef GAMEOVER_BLINK_EN
            bcnt      <= bcnt_adv;
            bus.blink <= blink_adv;
`endif
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_gameover_ctl.sv
// tb_gameover_ctl: directed stimulus for gameover_ctl, checked every cycle
// against a result-level model (candidate run length, ticks since over)
// plus hand-computed literal expectations.
module tb_gameover_ctl;
  localparam int CF = 2;
  localparam int MO = 60;
  localparam int BF = 30;
`ifdef GAMEOVER_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gameover_ctl_if bus();

  gameover_ctl #(
    .CONFIRM_FRAMES (CF),
    .MIN_OVER_FRAMES(MO),
    .BLINK_FRAMES   (BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: result-level bookkeeping
  bit         m_over, m_rel, m_rd, m_tick, m_pv;
  logic [1:0] m_win, m_cand;
  int         m_run, m_held, m_bt;

  always @(posedge clk) begin
    bit t;
    t    = m_tick;
    m_rd = 1'b0;
    if (rst) begin
      m_over = 0; m_rel = 0; m_tick = 0; m_pv = 0;
      m_win = 0; m_cand = 0; m_run = 0; m_held = 0; m_bt = 0;
    end else begin
      if (!m_over) begin
        if (bus.reset || bus.gameover == 2'b00) begin
          m_cand = 0; m_run = 0;
        end else if (bus.gameover != m_cand) begin
          m_cand = bus.gameover; m_run = 0;
        end else if (t) begin
          m_run++;
          if (m_run == CF) begin
            m_over = 1; m_win = m_cand; m_held = 0; m_bt = 0; m_rel = 0;
            m_cand = 0; m_run = 0;
          end
        end
      end else if (m_rel && !bus.reset && bus.gameover == 2'b00) begin
        m_over = 0; m_win = 0; m_rd = 1; m_rel = 0;
      end else begin
        if (t) m_bt++;
        if (!m_rel) begin
          if (m_held >= MO && bus.reset) m_rel = 1;
          else if (t && m_held < MO) m_held++;
        end
      end
      m_tick = bus.vblnk && !m_pv;
      m_pv   = bus.vblnk;
    end
  end

  function automatic logic exp_blink();
    if (!m_over) return 1'b0;
    if (BLINK_EN) return ((m_bt / BF) % 2) == 0;
    return 1'b1;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("over", {3'b0, bus.over}, {3'b0, m_over});
      check("winner", {2'b0, bus.winner}, {2'b0, m_win});
      check("blink", {3'b0, bus.blink}, {3'b0, exp_blink()});
      check("restart_done", {3'b0, bus.restart_done}, {3'b0, m_rd});
      if (bus.restart_done === 1'b1) pulses++;
    end
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.vblnk = 1'b1;
      repeat (3) begin
        @(negedge clk);
        bus.vblnk = 1'b0;
      end
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.reset = 1'b0; bus.gameover = 2'b00; bus.vblnk = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_over", {3'b0, bus.over}, 4'd0);
    check("rst_winner", {2'b0, bus.winner}, 4'd0);
    check("rst_blink", {3'b0, bus.blink}, 4'd0);
    check("rst_restart", {3'b0, bus.restart_done}, 4'd0);
    rst = 1'b0;

    // 01 held for two ticks
    bus.gameover = 2'b01;
    frames(1);
    check("one_tick_over", {3'b0, bus.over}, 4'd0);
    frames(1);
    check("two_tick_over", {3'b0, bus.over}, 4'd1);
    check("two_tick_winner", {2'b0, bus.winner}, 4'd1);

    // Winner holds while gameover changes; restart blocked before 60 frames
    bus.gameover = 2'b10;
    frames(10);
    check("winner_hold", {2'b0, bus.winner}, 4'd1);
    check("blink_f10", {3'b0, bus.blink}, 4'd1);
    bus.gameover = 2'b00;
    frames(20);
    bus.reset = 1'b1;
    frames(5);
    bus.reset = 1'b0;
    frames(2);
    check("early_reset_over", {3'b0, bus.over}, 4'd1);
    check("early_reset_pulses", pulses[3:0], 4'd0);
    check("blink_f37", {3'b0, bus.blink}, BLINK_EN ? 4'd0 : 4'd1);
    bus.reset = 1'b1;
    frames(30);
    check("release_over", {3'b0, bus.over}, 4'd1);
    check("blink_f67", {3'b0, bus.blink}, 4'd1);
    bus.reset = 1'b0;
    repeat (3) @(negedge clk);
    check("restart_over", {3'b0, bus.over}, 4'd0);
    check("restart_winner", {2'b0, bus.winner}, 4'd0);
    check("restart_pulses", pulses[3:0], 4'd1);

    // Candidate reload: 10 for one tick, then 01 for two
    bus.gameover = 2'b10;
    frames(1);
    bus.gameover = 2'b01;
    frames(1);
    check("reload_over_early", {3'b0, bus.over}, 4'd0);
    frames(1);
    check("reload_over", {3'b0, bus.over}, 4'd1);
    check("reload_winner", {2'b0, bus.winner}, 4'd1);

    // rst mid-OVER, then timeout code reconfirms
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    bus.gameover = 2'b11;
    check("midover_rst_over", {3'b0, bus.over}, 4'd0);
    check("midover_rst_winner", {2'b0, bus.winner}, 4'd0);
    check("midover_rst_blink", {3'b0, bus.blink}, 4'd0);
    frames(2);
    check("timeout_over", {3'b0, bus.over}, 4'd1);
    check("timeout_winner", {2'b0, bus.winner}, 4'd3);

    // vblnk held high counts one tick only
    pulse_rst();
    bus.gameover = 2'b01;
    @(negedge clk) bus.vblnk = 1'b1;
    repeat (100) @(negedge clk);
    bus.vblnk = 1'b0;
    repeat (3) @(negedge clk);
    check("vblnk_high_over", {3'b0, bus.over}, 4'd0);
    frames(1);
    check("vblnk_next_over", {3'b0, bus.over}, 4'd1);

    // reset during CONFIRM clears the count and gives no pulse
    pulse_rst();
    bus.gameover = 2'b10;
    frames(1);
    @(negedge clk) bus.reset = 1'b1;
    @(negedge clk) bus.reset = 1'b0;
    frames(1);
    check("confirm_reset_over", {3'b0, bus.over}, 4'd0);
    frames(1);
    check("confirm_reset_over2", {3'b0, bus.over}, 4'd1);
    check("confirm_reset_winner", {2'b0, bus.winner}, 4'd2);
    check("final_pulses", pulses[3:0], 4'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
